// File: rtl/vector_mem_seq.sv
// Vector load/store sequencer: serializes a 256-bit VST into 16 element writes, and
// gathers 16 element reads into a 256-bit VLD result.
module vector_mem_seq #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned ELEMS  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               functype,
  input  logic [15:0]              addr,
  input  logic [ELEM_W*ELEMS-1:0]  storeData,
  output logic [15:0]              memAddr,
  output logic [ELEM_W-1:0]        memWrData,
  output logic                     memWr,
  output logic                     memRd,
  input  logic [ELEM_W-1:0]        memRdData,
  output logic [ELEM_W*ELEMS-1:0]  loadData,
  output logic                     loadValid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CW = $clog2(ELEMS);
  localparam logic [3:0] FnVld = 4'b0100;
  localparam logic [3:0] FnVst = 4'b0101;

  typedef enum logic [2:0] {StIdle, StStore, StLoad, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cap_q;
  logic              rd_q;
  logic              is_vld_q;
  logic [15:0]       base_q;
  logic [ELEM_W-1:0] st_lanes_q [ELEMS];
  logic [ELEM_W-1:0] ld_lanes_q [ELEMS];

  logic accept;
  logic last;

  assign accept = start && !busy && (functype == FnVld || functype == FnVst);
  assign last   = (cnt_q == CW'(ELEMS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = (functype == FnVst) ? StStore : StLoad;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StStore: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = StDone;
      end
      StLoad: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are decoded from state so that reset forces them low on the next cycle.
  always_comb begin
    memAddr   = '0;
    memWrData = '0;
    memWr     = 1'b0;
    memRd     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    loadValid = 1'b0;
    unique case (state_q)
      StStore: begin
        memWr     = 1'b1;
        memAddr   = base_q + 16'(cnt_q);
        memWrData = st_lanes_q[cnt_q];
        busy      = 1'b1;
      end
      StLoad: begin
        memRd   = 1'b1;
        memAddr = base_q + 16'(cnt_q);
        busy    = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone: begin
        done      = 1'b1;
        loadValid = is_vld_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cap_q    <= '0;
      rd_q     <= 1'b0;
      is_vld_q <= 1'b0;
      base_q   <= '0;
      for (int i = 0; i < int'(ELEMS); i++) ld_lanes_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Read data arrives one cycle after the strobe; rd_q marks the capture cycle.
      rd_q    <= memRd;
      if (accept) begin
        base_q   <= addr;
        is_vld_q <= (functype == FnVld);
        cap_q    <= '0;
        if (functype == FnVst) begin
          for (int i = 0; i < int'(ELEMS); i++) begin
            st_lanes_q[i] <= storeData[i*ELEM_W +: ELEM_W];
          end
        end
      end
      if (rd_q) begin
        ld_lanes_q[cap_q] <= memRdData;
        cap_q             <= cap_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < int'(ELEMS); g++) begin : g_load
    assign loadData[g*ELEM_W +: ELEM_W] = ld_lanes_q[g];
  end

endmodule
